// File: rtl/sub_lab_pkg.sv
// Shared types for the subtractor-lab front end.
// Holds the sequencer state encoding and default datapath width.
package sub_lab_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    CALC   = 2'd2,
    SHOW   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces a raw push-button.
// Ports: clk, rst_n, raw (async in), level (debounced), press (1-cycle rise pulse).
module button_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = SYNC_STAGES'({sync_q, raw});
    cnt_d   = cnt_q;
    level_d = level_q;
    // Any cycle of agreement restarts the stability count.
    if (synced != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_d   = '0;
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/operand_sequencer.sv
// Captures A then B on Enter presses, feeds the adder, latches its result.
// Ports: sw/sub/enter in, Comp from adder; NumA/NumB/result/result_valid/state out.
module operand_sequencer #(
  parameter int WIDTH           = sub_lab_pkg::WIDTH,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             sub,
  input  logic             enter,
  input  logic [WIDTH-1:0] Comp,
  output logic [WIDTH-1:0] NumA,
  output logic [WIDTH-1:0] NumB,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [1:0]       state
);

  import sub_lab_pkg::*;

  logic btn_level;
  logic btn_press;
  logic take;

  button_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (enter),
    .level(btn_level),
    .press(btn_press)
  );

  // A press is only honoured while the debounced level agrees with it.
  assign take = btn_press & btn_level;

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    result_d = result_q;
    valid_d  = valid_q;
    unique case (state_q)
      LOAD_A: begin
        if (take) begin
          a_d     = sw;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (take) begin
          b_d     = sw;
          sub_d   = sub;
          state_d = CALC;
        end
      end
      // One cycle for NumB to settle through the adder; press ignored.
      CALC: begin
        result_d = Comp;
        valid_d  = 1'b1;
        state_d  = SHOW;
      end
      SHOW: begin
        if (take) begin
          valid_d = 1'b0;
          a_d     = '0;
          b_d     = '0;
          state_d = LOAD_A;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign NumA         = a_q;
  assign NumB         = sub_q ? ~b_q : b_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign state        = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer with a ones'-complement adder downstream.
// Window-based button model plus operation-level sequencer model.
module tb_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = '0;
  logic       sub = 1'b0;
  logic       enter = 1'b0;
  logic [3:0] comp;
  logic [3:0] num_a, num_b, result;
  logic       result_valid;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  operand_sequencer #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .sub(sub),
    .enter(enter), .Comp(comp), .NumA(num_a), .NumB(num_b),
    .result(result), .result_valid(result_valid), .state(state)
  );

  function automatic logic [3:0] ocadd(input logic [3:0] a,
                                       input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[3:0] + {3'b0, s[4]};
  endfunction

  assign comp = ocadd(num_a, num_b);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the debounced level flips once the raw button, seen two
  // edges late, has disagreed with it on four consecutive edges.
  logic       hist [6];
  logic       lvl_m, prs_m, sub_m, val_m;
  logic [3:0] a_m, b_m, res_m;
  int         st_m;

  function automatic logic [3:0] numb_m();
    return sub_m ? ~b_m : b_m;
  endfunction

  initial forever begin
    logic cap, tog;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) hist[i] = 1'b0;
      lvl_m = 0; prs_m = 0; sub_m = 0; val_m = 0;
      a_m = 0; b_m = 0; res_m = 0; st_m = 0;
    end else begin
      for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = enter;
      tog = (hist[2] != lvl_m) && (hist[3] != lvl_m) &&
            (hist[4] != lvl_m) && (hist[5] != lvl_m);
      cap = prs_m;
      prs_m = tog && !lvl_m;
      if (tog) lvl_m = !lvl_m;
      case (st_m)
        0: if (cap) begin a_m = sw; st_m = 1; end
        1: if (cap) begin b_m = sw; sub_m = sub; st_m = 2; end
        2: begin res_m = ocadd(a_m, numb_m()); val_m = 1; st_m = 3; end
        default: if (cap) begin
          val_m = 0; a_m = 0; b_m = 0; st_m = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("numa", int'(num_a), int'(a_m));
      chk("numb", int'(num_b), int'(numb_m()));
      chk("result", int'(result), int'(res_m));
      chk("valid", int'(result_valid), int'(val_m));
      chk("state", int'(state), st_m);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] v, input logic s);
    sw = v; sub = s; enter = 1'b1;
    cyc(10);
    enter = 1'b0;
    cyc(10);
  endtask

  task automatic lit(input string tag, input int st, input int na,
                     input int nb, input int res, input int vl);
    chk({tag, "_state"}, int'(state), st);
    chk({tag, "_numa"}, int'(num_a), na);
    chk({tag, "_numb"}, int'(num_b), nb);
    chk({tag, "_result"}, int'(result), res);
    chk({tag, "_valid"}, int'(result_valid), vl);
  endtask

  initial begin
    cyc(2);
    lit("por", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(2);

    // Reset mid-operation from LOAD_B
    push(4'b0101, 1'b0);
    chk("ld_b_state", int'(state), 1);
    chk("ld_b_numa", int'(num_a), 5);
    #2 rst_n = 1'b0;
    #1 lit("async_rst", 0, 0, 0, 0, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // 5 - 3
    push(4'b0101, 1'b0);
    push(4'b0011, 1'b1);
    lit("s53", 3, 5, 12, 2, 1);
    push(4'b0000, 1'b0);
    chk("s53_back", int'(state), 0);

    // 3 - 5
    push(4'b0011, 1'b0);
    push(4'b0101, 1'b1);
    lit("s35", 3, 3, 10, 13, 1);
    push(4'b0000, 1'b0);

    // 3 + 4
    push(4'b0011, 1'b0);
    push(4'b0100, 1'b0);
    lit("a34", 3, 3, 4, 7, 1);
    push(4'b0000, 1'b0);

    // Bounce rejection
    sw = 4'b0110;
    repeat (5) begin
      enter = 1'b1; cyc(3);
      enter = 1'b0; cyc(2);
    end
    chk("bounce_none", int'(state), 0);
    enter = 1'b1; cyc(10);
    enter = 1'b0; cyc(10);
    chk("bounce_one", int'(state), 1);
    chk("bounce_a", int'(num_a), 6);
    push(4'b0010, 1'b0);
    lit("a62", 3, 6, 2, 8, 1);

    // Hold in SHOW
    enter = 1'b1;
    cyc(50);
    chk("hold_state", int'(state), 0);
    chk("hold_valid", int'(result_valid), 0);
    sw = 4'b1111;
    cyc(5);
    chk("hold_nocap", int'(state), 0);
    chk("hold_numa", int'(num_a), 0);
    enter = 1'b0;
    cyc(10);
    chk("rel_state", int'(state), 0);
    push(4'b1001, 1'b0);
    chk("new_press", int'(state), 1);
    chk("new_numa", int'(num_a), 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
